stage5_writeback: RTL and testbench

STAGE5_WRITEBACK -- requirements
Module: stage5_writeback

---
 rtl/stage5_writeback.sv | 175 +++++++++++++++++
 tb/tb_stage5_writeback.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage5_writeback.sv
// MEM/WB writeback stage: load alignment, fault/timeout detection, register-file write port.
// Optional retired-instruction counter enabled by defining RETIRE_CNT_EN.
module stage5_writeback #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_ir,
    input  logic [31:0] in_alu,
    input  logic        in_load,
    input  logic        in_reg_dest,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wb_fwd_en,
    output logic [31:0] wb_fwd,
    output logic        err,
    output logic [63:0] retire_count
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [4:0]       rd_q, rd_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic             dest_q, dest_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic             err_q, err_d;
    logic             retire_inc;

    logic [31:0] load_data;
    logic        load_fault;
    logic [31:0] shifted;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        shifted  = mem_rdata >> {off_q, 3'b000};
        sel_byte = shifted[7:0];
        sel_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data  = mem_rdata;
        load_fault = 1'b0;
        case (f3_q)
            3'b000: load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100: load_data = {24'h0, sel_byte};
            3'b001: begin
                load_data  = {{16{sel_half[15]}}, sel_half};
                load_fault = off_q[0];
            end
            3'b101: begin
                load_data  = {16'h0, sel_half};
                load_fault = off_q[0];
            end
            3'b010: load_fault = (off_q != 2'b00);
            default: load_fault = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        off_d      = off_q;
        dest_d     = dest_q;
        cnt_d      = cnt_q;
        cnt_inc    = cnt_q + 1'b1;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        err_d      = err_q;
        retire_inc = 1'b0;
        if (state_q == IDLE) begin
            if (in_valid) begin
                if (in_load) begin
                    rd_d    = in_ir[11:7];
                    f3_d    = in_ir[14:12];
                    off_d   = in_alu[1:0];
                    dest_d  = in_reg_dest;
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    rf_we_d    = in_reg_dest & (in_ir[11:7] != 5'd0);
                    rf_waddr_d = in_ir[11:7];
                    rf_wdata_d = in_alu;
                    retire_inc = 1'b1;
                end
            end
        end else begin
            // A response on the same edge the timeout would expire takes priority.
            if (mem_ready) begin
                rf_we_d    = dest_q & (rd_q != 5'd0) & ~load_fault;
                rf_waddr_d = rd_q;
                rf_wdata_d = load_data;
                err_d      = err_q | load_fault;
                retire_inc = 1'b1;
                state_d    = IDLE;
            end else if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
                cnt_d      = cnt_inc;
                err_d      = 1'b1;
                retire_inc = 1'b1;
                state_d    = IDLE;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            dest_q     <= 1'b0;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            dest_q     <= dest_d;
            cnt_q      <= cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    assign stall     = (state_q == WAIT);
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign wb_fwd_en = rf_we_q;
    assign wb_fwd    = rf_wdata_q;
    assign err       = err_q;

`ifdef RETIRE_CNT_EN
    logic [63:0] retire_q, retire_d;

    always_comb begin
        retire_d = retire_q + {63'h0, retire_inc};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) retire_q <= '0;
        else        retire_q <= retire_d;
    end

    assign retire_count = retire_q;
`else
    logic unused_retire;
    assign unused_retire = retire_inc;
    assign retire_count  = '0;
`endif

    logic unused_ir;
    assign unused_ir = ^{in_ir[31:15], in_ir[6:0]};

endmodule

// File: tb/tb_stage5_writeback.sv
// Scoreboard bench for stage5_writeback: expected writes queued at stimulus, popped at DUT output.
module tb_stage5_writeback;

    localparam int unsigned TO = 16;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_ir;
    logic [31:0] in_alu;
    logic        in_load;
    logic        in_reg_dest;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_fwd_en;
    logic [31:0] wb_fwd;
    logic        err;
    logic [63:0] retire_count;

    stage5_writeback #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ir(in_ir), .in_alu(in_alu),
        .in_load(in_load), .in_reg_dest(in_reg_dest), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .wb_fwd_en(wb_fwd_en), .wb_fwd(wb_fwd), .err(err),
        .retire_count(retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        err;
        bit          chk_data;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_retire = '0;
    logic        exp_err = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [4:0] rd);
        return {17'h0, f3, rd, 7'h03};
    endfunction

    task automatic bump_retire();
`ifdef RETIRE_CNT_EN
        exp_retire = exp_retire + 64'd1;
`endif
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_ir = '0; in_alu = '0; in_load = 1'b0;
        in_reg_dest = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b1;
        exp_retire = '0;
        exp_err = 1'b0;
        sb.delete();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        in_valid = 1'b1; in_ir = mk_ir(3'b000, 5'd4); in_alu = 32'h55AA_55AA; in_reg_dest = 1'b1;
        repeat (3) tick();
        checks++;
        if ({stall, rf_we, rf_waddr, rf_wdata, wb_fwd_en, wb_fwd, err, retire_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got stall=%0b we=%0b waddr=%0h wdata=%0h fwd_en=%0b fwd=%0h err=%0b ret=%0h want all 0",
                     stall, rf_we, rf_waddr, rf_wdata, wb_fwd_en, wb_fwd, err, retire_count);
        end
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle got we=%0b want 0", rf_we);
        end
    endtask

    task automatic test_nonload(input logic [4:0] rd, input logic [31:0] alu, input logic dest);
        in_valid = 1'b1; in_load = 1'b0; in_ir = mk_ir(3'b000, rd); in_alu = alu; in_reg_dest = dest;
        sb.push_back('{we: dest && rd != 0, waddr: rd, wdata: alu, err: exp_err, chk_data: dest && rd != 0});
        bump_retire();
        tick();
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (rf_we !== e.we || wb_fwd_en !== e.we || stall !== 1'b0) begin
            failures++;
            $display("FAIL nonload_we rd=%0d got we=%0b fwd_en=%0b stall=%0b want we=%0b stall=0",
                     rd, rf_we, wb_fwd_en, stall, e.we);
        end
        if (e.chk_data) begin
            checks++;
            if (rf_waddr !== e.waddr || rf_wdata !== e.wdata || wb_fwd !== e.wdata) begin
                failures++;
                $display("FAIL nonload_data got waddr=%0d wdata=%0h fwd=%0h want waddr=%0d wdata=%0h",
                         rf_waddr, rf_wdata, wb_fwd, e.waddr, e.wdata);
            end
        end
        checks++;
        if (retire_count !== exp_retire || err !== e.err) begin
            failures++;
            $display("FAIL nonload_retire_err got ret=%0d err=%0b want ret=%0d err=%0b",
                     retire_count, err, exp_retire, e.err);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || (e.chk_data && rf_wdata !== e.wdata)) begin
            failures++;
            $display("FAIL nonload_one_cycle got we=%0b wdata=%0h want we=0 wdata=%0h", rf_we, rf_wdata, e.wdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_load = 1'b0; in_reg_dest = 1'b1;
            in_ir = mk_ir(3'b000, 5'(k + 1)); in_alu = 32'h1000_0000 + 32'(k);
            sb.push_back('{we: 1'b1, waddr: 5'(k + 1), wdata: 32'h1000_0000 + 32'(k), err: exp_err, chk_data: 1'b1});
            bump_retire();
            tick();
            e = sb.pop_front();
            checks++;
            if (rf_we !== e.we || rf_waddr !== e.waddr || rf_wdata !== e.wdata) begin
                failures++;
                $display("FAIL b2b_%0d got we=%0b waddr=%0d wdata=%0h want we=1 waddr=%0d wdata=%0h",
                         k, rf_we, rf_waddr, rf_wdata, e.waddr, e.wdata);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (rf_we !== 1'b0 || retire_count !== exp_retire) begin
            failures++;
            $display("FAIL b2b_end got we=%0b ret=%0d want we=0 ret=%0d", rf_we, retire_count, exp_retire);
        end
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [4:0] rd,
                             input logic [31:0] alu, input logic dest, input logic [31:0] rdata,
                             input int nwait, input logic exp_we, input logic [31:0] exp_data,
                             input logic fault);
        int stall_cnt;
        int we_cnt;
        stall_cnt = 0;
        we_cnt = 0;
        in_valid = 1'b1; in_load = 1'b1; in_ir = mk_ir(f3, rd); in_alu = alu; in_reg_dest = dest;
        exp_err = exp_err | fault;
        sb.push_back('{we: exp_we, waddr: rd, wdata: exp_data, err: exp_err, chk_data: exp_we});
        tick();
        // Upstream keeps offering an unrelated bundle while stalled; it must be ignored.
        in_load = 1'b0; in_ir = mk_ir(3'b000, 5'd7); in_alu = 32'h0000_0BAD;
        for (int i = 0; i < nwait; i++) begin
            if (stall === 1'b1) stall_cnt++;
            if (rf_we === 1'b1) we_cnt++;
            if (i == nwait - 1) begin
                mem_ready = 1'b1;
                mem_rdata = rdata;
            end
            tick();
        end
        in_valid = 1'b0;
        mem_ready = 1'b0;
        bump_retire();
        e = sb.pop_front();
        checks++;
        if (stall_cnt != nwait || we_cnt != 0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL %s_stall got stall_cycles=%0d we_in_wait=%0d stall_after=%0b want %0d 0 0",
                     name, stall_cnt, we_cnt, stall, nwait);
        end
        checks++;
        if (rf_we !== e.we || wb_fwd_en !== e.we || err !== e.err) begin
            failures++;
            $display("FAIL %s_we got we=%0b fwd_en=%0b err=%0b want we=%0b err=%0b",
                     name, rf_we, wb_fwd_en, err, e.we, e.err);
        end
        if (e.chk_data) begin
            checks++;
            if (rf_waddr !== e.waddr || rf_wdata !== e.wdata || wb_fwd !== e.wdata) begin
                failures++;
                $display("FAIL %s_data got waddr=%0d wdata=%0h fwd=%0h want waddr=%0d wdata=%0h",
                         name, rf_waddr, rf_wdata, wb_fwd, e.waddr, e.wdata);
            end
        end
        checks++;
        if (retire_count !== exp_retire) begin
            failures++;
            $display("FAIL %s_retire got %0d want %0d", name, retire_count, exp_retire);
        end
    endtask

    task automatic test_idle_ready();
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) tick();
        mem_ready = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || stall !== 1'b0 || retire_count !== exp_retire) begin
            failures++;
            $display("FAIL idle_ready got we=%0b stall=%0b ret=%0d want 0 0 %0d",
                     rf_we, stall, retire_count, exp_retire);
        end
    endtask

    task automatic test_err_sticky();
        repeat (3) tick();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got %0b want 1", err);
        end
    endtask

    task automatic test_timeout();
        int stall_cnt;
        stall_cnt = 0;
        in_valid = 1'b1; in_load = 1'b1; in_ir = mk_ir(3'b010, 5'd6); in_alu = 32'h0000_0100;
        in_reg_dest = 1'b1;
        exp_err = 1'b1;
        sb.push_back('{we: 1'b0, waddr: 5'd6, wdata: 32'h0, err: 1'b1, chk_data: 1'b0});
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (stall !== 1'b1) break;
            stall_cnt++;
            tick();
        end
        bump_retire();
        e = sb.pop_front();
        checks++;
        if (stall_cnt != TO || stall !== 1'b0) begin
            failures++;
            $display("FAIL timeout_stall got stall_cycles=%0d stall=%0b want %0d 0", stall_cnt, stall, TO);
        end
        checks++;
        if (rf_we !== e.we || err !== e.err || retire_count !== exp_retire) begin
            failures++;
            $display("FAIL timeout_result got we=%0b err=%0b ret=%0d want we=0 err=1 ret=%0d",
                     rf_we, err, retire_count, exp_retire);
        end
    endtask

    task automatic test_reset_mid_wait();
        test_nonload(5'd11, 32'hFEED_FACE, 1'b1);
        in_valid = 1'b1; in_load = 1'b1; in_ir = mk_ir(3'b000, 5'd9); in_alu = 32'h0;
        in_reg_dest = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({stall, rf_we, rf_waddr, rf_wdata, wb_fwd_en, wb_fwd, err, retire_count} !== '0) begin
            failures++;
            $display("FAIL midwait_reset got stall=%0b we=%0b waddr=%0h wdata=%0h err=%0b ret=%0h want all 0",
                     stall, rf_we, rf_waddr, rf_wdata, err, retire_count);
        end
        exp_retire = '0;
        exp_err = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h0000_0011;
        tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || stall !== 1'b0 || err !== 1'b0 || retire_count !== exp_retire) begin
            failures++;
            $display("FAIL midwait_ready_ignored got we=%0b stall=%0b err=%0b ret=%0d want 0 0 0 %0d",
                     rf_we, stall, err, retire_count, exp_retire);
        end
        test_nonload(5'd13, 32'h0BAD_CAFE, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_nonload(5'd5, 32'h1234_5678, 1'b1);
        test_nonload(5'd0, 32'hDEAD_BEEF, 1'b1);
        test_nonload(5'd12, 32'hCAFE_F00D, 1'b0);
        test_back_to_back();
        test_load("lb",   3'b000, 5'd3,  32'h0000_1002, 1'b1, 32'h0080_0000, 3,  1'b1, 32'hFFFF_FF80, 1'b0);
        test_load("lbu",  3'b100, 5'd3,  32'h0000_1002, 1'b1, 32'h0080_0000, 3,  1'b1, 32'h0000_0080, 1'b0);
        test_load("lb3",  3'b000, 5'd8,  32'h0000_0003, 1'b1, 32'h7F00_0000, 1,  1'b1, 32'h0000_007F, 1'b0);
        test_load("lh2",  3'b001, 5'd14, 32'h0000_0002, 1'b1, 32'h8001_1234, 2,  1'b1, 32'hFFFF_8001, 1'b0);
        test_load("lhu0", 3'b101, 5'd15, 32'h0000_0000, 1'b1, 32'h8001_9234, 2,  1'b1, 32'h0000_9234, 1'b0);
        test_load("lw",   3'b010, 5'd16, 32'h0000_0040, 1'b1, 32'hA5A5_5A5A, 4,  1'b1, 32'hA5A5_5A5A, 1'b0);
        test_load("lwnd", 3'b010, 5'd17, 32'h0000_0040, 1'b0, 32'h1111_2222, 2,  1'b0, 32'h0,         1'b0);
        test_load("lw16", 3'b010, 5'd18, 32'h0000_0080, 1'b1, 32'h3C3C_C3C3, TO, 1'b1, 32'h3C3C_C3C3, 1'b0);
        test_idle_ready();
        test_load("lwmis", 3'b010, 5'd19, 32'h0000_0001, 1'b1, 32'h1234_5678, 2, 1'b0, 32'h0, 1'b1);
        test_err_sticky();
        test_load("lhmis", 3'b001, 5'd20, 32'h0000_0003, 1'b1, 32'h1234_5678, 1, 1'b0, 32'h0, 1'b1);
        test_load("f3bad", 3'b011, 5'd21, 32'h0000_0000, 1'b1, 32'h1234_5678, 1, 1'b0, 32'h0, 1'b1);
        test_nonload(5'd22, 32'h7777_8888, 1'b1);
        apply_reset();
        test_timeout();
        test_err_sticky();
        apply_reset();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
